state_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream state consumer between `NumReq` requesters whose payload type is a type parameter, typically an enum such as an 8-bit or 9-bit state encoding. Each requester offers a value with a valid/ready handshake. The arbiter registers the winner into a one-entry output buffer and presents it to the consumer with its own valid/ready handshake. It sits between several state producers and a single module whose state input port is typed by the same type parameter.

---
 rtl/state_rr_arbiter_pkg.sv | 18 +
 rtl/state_rr_arbiter_pick.sv | 36 +++
 rtl/state_rr_arbiter.sv | 83 ++++++++
 tb/tb_state_rr_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/state_rr_arbiter_pkg.sv
// Shared types for the round-robin state arbiter: FSM encoding and the
// sample payload enums the arbiter is exercised with.
package state_arb_pkg;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

  typedef enum logic [7:0] {
    FooVariant = 8'b10010101
  } enum_foo_e;

  typedef enum logic [8:0] {
    BarVariant = 9'b100100001
  } enum_bar_e;

endpackage

// File: rtl/state_rr_arbiter_pick.sv
// Combinational round-robin picker: first asserted valid at or above the
// pointer, wrapping to the lowest asserted valid when none is found above.
module rr_pick #(
  parameter int unsigned NumReq = 2,
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] i_valid,
  input  logic [IdxW-1:0]   i_ptr,
  output logic              o_found,
  output logic [IdxW-1:0]   o_idx
);

  logic            w_hi_found;
  logic [IdxW-1:0] w_hi_idx;
  logic [IdxW-1:0] w_lo_idx;

  // Descending scans so the lowest qualifying index is the one left standing.
  always_comb begin
    o_found    = 1'b0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (i_valid[i]) begin
        o_found  = 1'b1;
        w_lo_idx = IdxW'(i);
      end
      if (i_valid[i] && (i >= int'(i_ptr))) begin
        w_hi_found = 1'b1;
        w_hi_idx   = IdxW'(i);
      end
    end
    o_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

endmodule

// File: rtl/state_rr_arbiter.sv
// Round-robin arbiter funnelling NumReq valid/ready state producers into a
// one-entry registered buffer feeding a single state consumer.
module state_rr_arbiter
  import state_arb_pkg::*;
#(
  parameter type         state_t = logic [8:0],
  parameter int unsigned NumReq  = 2,
  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_valid_i,
  input  state_t            req_state_i [NumReq],
  output logic [NumReq-1:0] req_ready_o,
  output logic              out_valid_o,
  output state_t            out_state_o,
  input  logic              out_ready_i,
  output logic [IdxW-1:0]   grant_idx_o
);

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  logic [IdxW-1:0] r_rr_ptr;
  logic [IdxW-1:0] w_ptr_nxt;
  state_t          r_out_state;
  logic [IdxW-1:0] r_grant_idx;
  logic            w_found;
  logic [IdxW-1:0] w_pick_idx;
  logic            w_can_accept;
  logic            w_accept;

  rr_pick #(
    .NumReq (NumReq)
  ) u_rr_pick (
    .i_valid (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  assign out_valid_o = (r_state == ARB_FULL);
  assign out_state_o = r_out_state;
  assign grant_idx_o = r_grant_idx;
  assign w_ptr_nxt   = (w_pick_idx == IdxW'(NumReq - 1)) ? '0 : w_pick_idx + 1'b1;

  // Accept decision: a drain in the same cycle frees the buffer, so fill and
  // drain overlap without a bubble. Ready is held low while in reset.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    req_ready_o  = '0;
    w_can_accept = (r_state == ARB_EMPTY) || (out_ready_i && out_valid_o);
    if (rst_ni && w_can_accept && w_found) begin
      w_accept                = 1'b1;
      req_ready_o[w_pick_idx] = 1'b1;
      w_state_nxt             = ARB_FULL;
    end else if ((r_state == ARB_FULL) && out_ready_i) begin
      w_state_nxt = ARB_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ARB_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output buffer stage: payload is copied untouched, so enum values survive.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_state <= state_t'('0);
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_out_state <= req_state_i[w_pick_idx];
      r_grant_idx <= w_pick_idx;
      r_rr_ptr    <= w_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_state_rr_arbiter.sv
// Bench for state_rr_arbiter: directed checks on enum-typed instances and a
// randomized run of a three-requester instance against a behavioural model.
module tb_state_rr_arbiter;
  import state_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Two-requester instance carrying enum_foo_e
  logic [1:0] f_valid;
  enum_foo_e  f_state [2];
  logic [1:0] f_ready;
  logic       f_ovalid;
  enum_foo_e  f_ostate;
  logic       f_oready;
  logic [0:0] f_gidx;

  // Two-requester instance carrying enum_bar_e
  logic [1:0] b_valid;
  enum_bar_e  b_state [2];
  logic [1:0] b_ready;
  logic       b_ovalid;
  enum_bar_e  b_ostate;
  logic       b_oready;
  logic [0:0] b_gidx;

  // Three-requester instance, default payload type
  logic [2:0] t_valid;
  logic [8:0] t_state [3];
  logic [2:0] t_ready;
  logic       t_ovalid;
  logic [8:0] t_ostate;
  logic       t_oready;
  logic [1:0] t_gidx;

  state_rr_arbiter #(.state_t(enum_foo_e), .NumReq(2)) u_foo (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(f_valid), .req_state_i(f_state),
    .req_ready_o(f_ready), .out_valid_o(f_ovalid), .out_state_o(f_ostate),
    .out_ready_i(f_oready), .grant_idx_o(f_gidx));

  state_rr_arbiter #(.state_t(enum_bar_e), .NumReq(2)) u_bar (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(b_valid), .req_state_i(b_state),
    .req_ready_o(b_ready), .out_valid_o(b_ovalid), .out_state_o(b_ostate),
    .out_ready_i(b_oready), .grant_idx_o(b_gidx));

  state_rr_arbiter #(.state_t(logic [8:0]), .NumReq(3)) u_tri (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(t_valid), .req_state_i(t_state),
    .req_ready_o(t_ready), .out_valid_o(t_ovalid), .out_state_o(t_ostate),
    .out_ready_i(t_oready), .grant_idx_o(t_gidx));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Round-robin rule: first valid requester starting at ptr, wrapping mod 3.
  function automatic int pick3(input logic [2:0] v, input int ptr);
    for (int j = 0; j < 3; j++) begin
      if (v[(ptr + j) % 3]) return (ptr + j) % 3;
    end
    return -1;
  endfunction

  // Reference model of the three-requester instance
  logic       m_full = 1'b0;
  logic [8:0] m_data = '0;
  int         m_gidx = 0;
  int         m_ptr  = 0;

  always @(posedge clk or negedge rst_n) begin : model_upd
    int k;
    if (!rst_n) begin
      m_full <= 1'b0;
      m_data <= '0;
      m_gidx <= 0;
      m_ptr  <= 0;
    end else begin
      k = pick3(t_valid, m_ptr);
      if ((!m_full || t_oready) && k >= 0) begin
        m_full <= 1'b1;
        m_data <= t_state[k];
        m_gidx <= k;
        m_ptr  <= (k + 1) % 3;
      end else if (m_full && t_oready) begin
        m_full <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin : model_cmp
    int k;
    logic [2:0] er;
    k  = pick3(t_valid, m_ptr);
    er = '0;
    if (rst_n && (!m_full || t_oready) && k >= 0) er = 3'(1 << k);
    chk("tri_ready", t_ready, er);
    chk("tri_ovalid", t_ovalid, m_full);
    chk("tri_gidx", t_gidx, m_gidx);
    chk("tri_state", t_ostate, m_data);
  end

  task automatic rand_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      t_valid  = 3'($urandom_range(0, 7));
      t_oready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) t_state[i] = 9'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    f_valid = '0; f_oready = 1'b0;
    f_state[0] = enum_foo_e'(8'h00); f_state[1] = enum_foo_e'(8'h00);
    b_valid = 2'b11; b_oready = 1'b0;
    b_state[0] = enum_bar_e'(9'h000); b_state[1] = enum_bar_e'(9'h000);
    t_valid = 3'b111; t_oready = 1'b0;
    for (int i = 0; i < 3; i++) t_state[i] = '0;

    // Reset values, ready forced low even with requests pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f_ovalid", f_ovalid, 0);
    chk("rst_f_ostate", f_ostate, 0);
    chk("rst_f_gidx", f_gidx, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_b_ovalid", b_ovalid, 0);
    chk("rst_b_ostate", b_ostate, 0);
    chk("rst_b_gidx", b_gidx, 0);
    b_valid = '0; t_valid = '0;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("idle_f_ovalid", f_ovalid, 0);
      chk("idle_b_ovalid", b_ovalid, 0);
    end

    // Single requester with enum_foo_e
    f_state[0] = FooVariant; f_state[1] = enum_foo_e'(8'h3C);
    f_valid = 2'b01; f_oready = 1'b1;
    #1 chk("foo_ready_first", f_ready, 2'b01);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("foo_ovalid", f_ovalid, 1);
      chk("foo_state", f_ostate, 8'b10010101);
      chk("foo_gidx", f_gidx, 0);
      chk("foo_ready", f_ready, 2'b01);
    end

    // Contention with enum_bar_e
    b_state[0] = BarVariant; b_state[1] = enum_bar_e'(9'h055);
    b_valid = 2'b11; b_oready = 1'b1;
    #1 chk("bar_ready_first", b_ready, 2'b01);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("bar_ovalid", b_ovalid, 1);
      chk("bar_gidx", b_gidx, k % 2);
      chk("bar_state", b_ostate, (k % 2 == 0) ? 9'b100100001 : 9'h055);
      chk("bar_ready", b_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
    end

    // Backpressure: buffer holds grant 1, pointer back at 0
    b_oready = 1'b0;
    #1 chk("bp_ready", b_ready, 0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("bp_ovalid", b_ovalid, 1);
      chk("bp_state", b_ostate, 9'h055);
      chk("bp_gidx", b_gidx, 1);
      chk("bp_ready", b_ready, 0);
    end
    b_oready = 1'b1;
    #1;
    chk("bp_release_ready", b_ready, 2'b01);
    chk("bp_release_ovalid", b_ovalid, 1);
    @(posedge clk); #1;
    chk("bp_after_ovalid", b_ovalid, 1);
    chk("bp_after_gidx", b_gidx, 0);
    chk("bp_after_state", b_ostate, 9'b100100001);

    // Wrap-around on the three-requester instance
    t_oready = 1'b1;
    t_state[0] = 9'h1A2; t_state[1] = 9'h0F0; t_state[2] = 9'h133;
    t_valid = 3'b100;
    #1 chk("wrap_ready2", t_ready, 3'b100);
    @(posedge clk); #1;
    chk("wrap_gidx2", t_gidx, 2);
    chk("wrap_state2", t_ostate, 9'h133);
    t_valid = 3'b001;
    #1 chk("wrap_ready0", t_ready, 3'b001);
    @(posedge clk); #1;
    chk("wrap_gidx0", t_gidx, 0);
    chk("wrap_state0", t_ostate, 9'h1A2);
    t_valid = 3'b111;
    #1 chk("wrap_ptr_is_1", t_ready, 3'b010);
    @(posedge clk); #1;
    chk("wrap_gidx1", t_gidx, 1);

    rand_cycles(400);

    // Mid-transfer reset: output must drop without a clock edge
    b_oready = 1'b0;
    @(posedge clk); #1;
    chk("mr_b_ovalid_before", b_ovalid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_b_ovalid", b_ovalid, 0);
    chk("mr_f_ovalid", f_ovalid, 0);
    chk("mr_b_gidx", b_gidx, 0);
    chk("mr_b_ostate", b_ostate, 0);
    chk("mr_b_ready", b_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    rand_cycles(300);
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
